// File: rtl/cfd_dac_pkg.sv
// Shared widths, the default channel count and the receive FSM state type
// for the DAC programming receiver.
package cfd_dac_pkg;

  localparam int DAC_MAG_W      = 5;
  localparam int DAC_SET_W      = 6;
  localparam int DAC_ADDR_W     = 5;
  localparam int DAC_NUM_CH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ADDR_WAIT = 2'd1,
    ST_DATA_WAIT = 2'd2
  } dac_state_e;

  // Observation bundle: FSM state plus synchronizer outputs that the
  // datapath itself does not consume.
  typedef struct packed {
    dac_state_e state;
    logic       stb_level;
    logic       sel_rise;
    logic       sel_fall;
    logic       sgn_rise;
    logic       sgn_fall;
  } dac_rx_dbg_t;

endpackage

// File: rtl/dac_in_sync.sv
// Multi-flop synchronizer for one asynchronous control input, followed by
// a rising/falling edge detector on the synchronized level.
module dac_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d_q;

  // Shift the raw input through the synchronizer and keep the previous
  // synchronized level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      level_d_q <= 1'b0;
    end else begin
      sync_q    <= (sync_q << 1) | SYNC_STAGES'(d);
      level_d_q <= level;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~level_d_q;
  assign fall  = ~level & level_d_q;

endmodule

// File: rtl/dac_prog_rx.sv
// DAC programming receiver: a sel_ext_addr window framing strobe cycles;
// the strobe rise latches a channel address from dac_data, the strobe fall
// commits {sign, magnitude} to that channel.
// Optional feature macro: DAC_PROG_READBACK_EN adds a registered readback
// port pair (rd_addr / rd_data).
module dac_prog_rx
  import cfd_dac_pkg::*;
#(
  parameter int NUM_CH      = DAC_NUM_CH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sel_ext_addr,
  input  logic                          dac_stb,
  input  logic [DAC_MAG_W-1:0]          dac_data,
  input  logic                          dac_sgn,
  output logic [NUM_CH*DAC_SET_W-1:0]   dac_set,
  output logic                          ext_addr_mode,
  output logic [DAC_ADDR_W-1:0]         ext_addr,
  output logic                          wr_pulse,
  output logic                          addr_err
`ifdef DAC_PROG_READBACK_EN
  ,
  input  logic [DAC_ADDR_W-1:0]         rd_addr,
  output logic [DAC_SET_W-1:0]          rd_data
`endif
);

  // Transfer protocol: there is no valid/ready pair here. The sender owns
  // the pace; a channel write is committed exactly when wr_pulse is high,
  // and dac_set already shows the new value in that same cycle.

  logic sel_s, sel_rise, sel_fall;
  logic stb_s, stb_rise, stb_fall;
  logic sgn_s, sgn_rise, sgn_fall;

  dac_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sel (
    .clk(clk), .rst_n(rst_n), .d(sel_ext_addr),
    .level(sel_s), .rise(sel_rise), .fall(sel_fall)
  );

  dac_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stb (
    .clk(clk), .rst_n(rst_n), .d(dac_stb),
    .level(stb_s), .rise(stb_rise), .fall(stb_fall)
  );

  dac_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sgn (
    .clk(clk), .rst_n(rst_n), .d(dac_sgn),
    .level(sgn_s), .rise(sgn_rise), .fall(sgn_fall)
  );

  dac_state_e               state_q, state_d;
  logic [DAC_ADDR_W-1:0]    ext_addr_q;
  logic                     wr_pulse_q;
  logic                     addr_err_q;
  logic [DAC_SET_W-1:0]     set_q [NUM_CH];
  logic                     addr_ld;
  logic                     wr_en;
  logic                     err_set;
  logic                     addr_in_range;
  dac_rx_dbg_t              unused_dbg;

  assign addr_in_range = int'(ext_addr_q) < NUM_CH;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and strobe actions; a low synchronized sel always wins
  // over a coincident strobe edge, so an abort never writes.
  always_comb begin
    state_d = state_q;
    addr_ld = 1'b0;
    wr_en   = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_s) state_d = ST_ADDR_WAIT;
      end
      ST_ADDR_WAIT: begin
        if (!sel_s) begin
          state_d = ST_IDLE;
        end else if (stb_rise) begin
          state_d = ST_DATA_WAIT;
          addr_ld = 1'b1;
        end
      end
      ST_DATA_WAIT: begin
        if (!sel_s) begin
          state_d = ST_IDLE;
        end else if (stb_fall) begin
          state_d = ST_ADDR_WAIT;
          if (addr_in_range) wr_en   = 1'b1;
          else               err_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address latch, write pulse and sticky address-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_addr_q <= '0;
      wr_pulse_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      if (addr_ld) ext_addr_q <= dac_data;
      wr_pulse_q <= wr_en;
      if (err_set) addr_err_q <= 1'b1;
    end
  end

  // Channel setting storage; dac_data is taken directly in the strobe-edge
  // cycle, the sign comes from its synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) set_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_en && (ext_addr_q == DAC_ADDR_W'(k))) set_q[k] <= {sgn_s, dac_data};
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign dac_set[g*DAC_SET_W +: DAC_SET_W] = set_q[g];
  end

  assign ext_addr_mode = sel_s;
  assign ext_addr      = ext_addr_q;
  assign wr_pulse      = wr_pulse_q;
  assign addr_err      = addr_err_q;

  assign unused_dbg = '{state: state_q, stb_level: stb_s, sel_rise: sel_rise,
                        sel_fall: sel_fall, sgn_rise: sgn_rise, sgn_fall: sgn_fall};

`ifdef DAC_PROG_READBACK_EN
  logic [DAC_SET_W-1:0] rd_data_d;
  logic [DAC_SET_W-1:0] rd_data_q;

  // Readback mux; an address beyond the channel count selects nothing.
  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_addr == DAC_ADDR_W'(k)) rd_data_d = set_q[k];
    end
  end

  // Register the readback value (one clock latency).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_dac_prog_rx.sv
// Self-checking bench for dac_prog_rx: directed scenarios plus randomized
// windows against a channel-array reference model and a write scoreboard.
module tb_dac_prog_rx;
  import cfd_dac_pkg::*;

  localparam int NUM_CH = 16;
  localparam int W      = NUM_CH * DAC_SET_W;

  logic                  clk;
  logic                  rst_n;
  logic                  sel_ext_addr;
  logic                  dac_stb;
  logic [DAC_MAG_W-1:0]  dac_data;
  logic                  dac_sgn;
  logic [W-1:0]          dac_set;
  logic                  ext_addr_mode;
  logic [DAC_ADDR_W-1:0] ext_addr;
  logic                  wr_pulse;
  logic                  addr_err;
`ifdef DAC_PROG_READBACK_EN
  logic [DAC_ADDR_W-1:0] rd_addr;
  logic [DAC_SET_W-1:0]  rd_data;
`endif

  dac_prog_rx #(.NUM_CH(NUM_CH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sel_ext_addr(sel_ext_addr), .dac_stb(dac_stb),
    .dac_data(dac_data), .dac_sgn(dac_sgn), .dac_set(dac_set),
    .ext_addr_mode(ext_addr_mode), .ext_addr(ext_addr), .wr_pulse(wr_pulse),
    .addr_err(addr_err)
`ifdef DAC_PROG_READBACK_EN
    , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model and scoreboard
  int                    checks = 0;
  int                    errors = 0;
  int                    wr_cnt = 0;
  logic [DAC_SET_W-1:0]  model [NUM_CH];
  logic                  model_err;
  logic [DAC_ADDR_W-1:0] exp_ext;
  logic [10:0]           exp_q[$];
  logic [10:0]           mon_exp;

  // Every wr_pulse must match the oldest expected write, and the addressed
  // field must already hold the expected value.
  always @(negedge clk) begin
    if (rst_n && wr_pulse) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: wr_pulse=1 ext_addr=%0d, required no write", ext_addr);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dac_set[int'(mon_exp[10:6])*DAC_SET_W +: DAC_SET_W] !== mon_exp[5:0]) begin
          errors++;
          $display("FAIL write_value ch%0d: got %b, required %b", mon_exp[10:6],
                   dac_set[int'(mon_exp[10:6])*DAC_SET_W +: DAC_SET_W], mon_exp[5:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [DAC_SET_W-1:0] get_ch(input int k);
    return dac_set[k*DAC_SET_W +: DAC_SET_W];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) model[k] = '0;
    model_err = 1'b0;
    exp_ext   = '0;
    exp_q.delete();
  endtask

  task automatic model_write(input int addr, input logic [DAC_SET_W-1:0] val);
    if (addr < NUM_CH) begin
      model[addr] = val;
      exp_q.push_back({5'(addr), val});
    end else begin
      model_err = 1'b1;
    end
  endtask

  // One complete sel window carrying a single address/data strobe.
  task automatic window(input int addr, input logic [DAC_MAG_W-1:0] mag, input logic sgn);
    sel_ext_addr = 1'b1;
    step($urandom_range(3, 6));
    dac_data = 5'(addr);
    step($urandom_range(1, 3));
    dac_stb = 1'b1;
    exp_ext = 5'(addr);
    step($urandom_range(4, 6));
    dac_data = mag;
    dac_sgn  = sgn;
    dac_stb  = 1'b0;
    model_write(addr, {sgn, mag});
    step($urandom_range(5, 7));
    sel_ext_addr = 1'b0;
    step($urandom_range(4, 6));
  endtask

  task automatic check_all(input string name);
    for (int k = 0; k < NUM_CH; k++) begin
      checks++;
      if (get_ch(k) !== model[k]) begin
        errors++;
        $display("FAIL %s ch%0d: got %b, required %b", name, k, get_ch(k), model[k]);
      end
    end
    checks++;
    if (addr_err !== model_err) begin
      errors++;
      $display("FAIL %s addr_err: got %b, required %b", name, addr_err, model_err);
    end
  endtask

  task automatic check_wr(input string name, input int base, input int delta);
    checks++;
    if (wr_cnt - base != delta) begin
      errors++;
      $display("FAIL %s wr_count: got %0d, required %0d", name, wr_cnt - base, delta);
    end
  endtask

  task automatic check_ext(input string name);
    checks++;
    if (ext_addr !== exp_ext) begin
      errors++;
      $display("FAIL %s ext_addr: got %0d, required %0d", name, ext_addr, exp_ext);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (dac_set !== '0 || ext_addr !== '0 || ext_addr_mode !== 1'b0 ||
        wr_pulse !== 1'b0 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: got dac_set=%h ext_addr=%0d mode=%b wr=%b err=%b, required all 0",
               name, dac_set, ext_addr, ext_addr_mode, wr_pulse, addr_err);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0; sel_ext_addr = 1'b0; dac_stb = 1'b0; dac_data = '0; dac_sgn = 1'b0;
`ifdef DAC_PROG_READBACK_EN
    rd_addr = '0;
`endif
    model_reset();
    step(3);
    check_zero_outputs("reset_state");
    rst_n = 1'b1;
    step(2);
    check_zero_outputs("after_release");
  endtask

  task automatic test_single_write();
    int base = wr_cnt;
    sel_ext_addr = 1'b1; dac_data = 5'd3;
    step(4);
    dac_stb = 1'b1; exp_ext = 5'd3;
    step(5);
    dac_sgn = 1'b0; dac_data = 5'd3; dac_stb = 1'b0;
    model_write(3, 6'b000011);
    step(2);
    checks++;
    if (get_ch(3) !== 6'b000000) begin
      errors++; $display("FAIL single_early: got %b, required 000000 at fall+2", get_ch(3));
    end
    step(1);
    checks++;
    if (get_ch(3) !== 6'b000011 || wr_pulse !== 1'b1) begin
      errors++; $display("FAIL single_latency: got %b wr=%b, required 000011 wr=1", get_ch(3), wr_pulse);
    end
    step(1);
    checks++;
    if (wr_pulse !== 1'b0) begin
      errors++; $display("FAIL single_pulse_width: got wr=%b, required 0", wr_pulse);
    end
    sel_ext_addr = 1'b0;
    step(5);
    check_wr("single", base, 1);
    check_ext("single");
  endtask

  task automatic test_all_channels();
    int base = wr_cnt;
    for (int ch = 0; ch < NUM_CH; ch++) window(ch, 5'd3, 1'b0);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      checks++;
      if (get_ch(ch) !== 6'b000011) begin
        errors++; $display("FAIL all_channels ch%0d: got %b, required 000011", ch, get_ch(ch));
      end
    end
    check_wr("all_channels", base, NUM_CH);
  endtask

  task automatic test_idle_window();
    int base = wr_cnt;
    int bad  = 0;
    sel_ext_addr = 1'b1; dac_data = 5'd5;
    step(3);
    for (int i = 0; i < 2260; i++) begin
      if (ext_addr_mode !== 1'b1 || wr_pulse !== 1'b0) bad++;
      step(1);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL idle_window_mode: got %0d bad cycles, required 0", bad);
    end
    sel_ext_addr = 1'b0;
    step(4);
    checks++;
    if (ext_addr_mode !== 1'b0) begin
      errors++; $display("FAIL idle_window_mode_off: got %b, required 0", ext_addr_mode);
    end
    check_wr("idle_window", base, 0);
    check_ext("idle_window");
    check_all("idle_window");
  endtask

  task automatic test_strobe_in_idle();
    int base = wr_cnt;
    sel_ext_addr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dac_data = 5'($urandom_range(0, 15));
      dac_stb  = 1'b1;
      step(4);
      dac_data = 5'($urandom_range(0, 31));
      dac_stb  = 1'b0;
      step(4);
    end
    check_wr("strobe_in_idle", base, 0);
    check_ext("strobe_in_idle");
    check_all("strobe_in_idle");
  endtask

  task automatic test_abort();
    int base = wr_cnt;
    sel_ext_addr = 1'b1; dac_data = 5'd7;
    step(4);
    dac_stb = 1'b1; exp_ext = 5'd7;
    step(5);
    sel_ext_addr = 1'b0;
    step(5);
    // Re-open the window with stb still high: only a stuck DATA_WAIT would
    // turn the coming fall into a write.
    sel_ext_addr = 1'b1;
    step(5);
    dac_data = 5'd9; dac_stb = 1'b0;
    step(5);
    sel_ext_addr = 1'b0;
    step(4);
    check_wr("abort", base, 0);
    check_ext("abort");
    check_all("abort");
  endtask

  task automatic test_sel_fall_same_cycle();
    int base = wr_cnt;
    sel_ext_addr = 1'b1; dac_data = 5'd4;
    step(4);
    dac_stb = 1'b1; exp_ext = 5'd4;
    step(5);
    dac_data = 5'd10; dac_sgn = 1'b1;
    sel_ext_addr = 1'b0; dac_stb = 1'b0;
    step(6);
    dac_sgn = 1'b0;
    check_wr("sel_fall_same_cycle", base, 0);
    check_all("sel_fall_same_cycle");
  endtask

  task automatic test_addr_err();
    int base = wr_cnt;
    checks++;
    if (addr_err !== 1'b0) begin
      errors++; $display("FAIL addr_err_pre: got %b, required 0", addr_err);
    end
    window(20, 5'd7, 1'b1);
    check_wr("addr_err_bad", base, 0);
    check_ext("addr_err_bad");
    check_all("addr_err_bad");
    window(2, 5'd17, 1'b1);
    checks++;
    if (get_ch(2) !== 6'b110001 || addr_err !== 1'b1) begin
      errors++; $display("FAIL addr_err_then_ch2: got %b err=%b, required 110001 err=1", get_ch(2), addr_err);
    end
    check_wr("addr_err_then_ch2", base, 1);
  endtask

  task automatic test_random();
    int base = wr_cnt;
    int good = 0;
    int a;
    for (int i = 0; i < 25; i++) begin
      a = $urandom_range(0, 19);
      if (a < NUM_CH) good++;
      window(a, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
    check_wr("random", base, good);
    check_ext("random");
    check_all("random");
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL random_pending: got %0d writes missing, required 0", exp_q.size());
    end
  endtask

`ifdef DAC_PROG_READBACK_EN
  task automatic test_readback();
    int a;
    logic [DAC_SET_W-1:0] exp;
    for (int i = 0; i < 12; i++) begin
      a = (i < 2) ? 16 + i * 15 : $urandom_range(0, 31);
      rd_addr = 5'(a);
      step(1);
      exp = (a < NUM_CH) ? model[a] : '0;
      checks++;
      if (rd_data !== exp) begin
        errors++; $display("FAIL readback addr%0d: got %b, required %b", a, rd_data, exp);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    int base;
    sel_ext_addr = 1'b1; dac_data = 5'd6;
    step(4);
    dac_stb = 1'b1;
    step(5);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_mid_immediate");
    model_reset();
    sel_ext_addr = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
    base = wr_cnt;
    dac_stb = 1'b0;
    step(6);
    check_wr("reset_mid_no_write", base, 0);
    check_all("reset_mid_no_write");
    window(1, 5'd9, 1'b0);
    check_wr("reset_mid_new_window", base, 1);
    check_all("reset_mid_new_window");
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_single_write();
    test_all_channels();
    test_idle_window();
    test_strobe_in_idle();
    test_abort();
    test_sel_fall_same_cycle();
    test_addr_err();
    test_random();
`ifdef DAC_PROG_READBACK_EN
    test_readback();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
